my_associative_lookup: RTL and testbench
========================================

MY_ASSOCIATIVE_LOOKUP -- requirements
Module: my_associative_lookup

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 4, key bit width.
REQ-002 SHALL have parameter DATA_WIDTH, default 2, data bit width.
REQ-003 SHALL have parameter DATA_NUMBER_LOG2, default 3, log2 of entry capacity (N = 2**DATA_NUMBER_LOG2).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port clr  input  1  clear-table command.
REQ-007 SHALL have port wr_en  input  1  write (insert/update) command.
REQ-008 SHALL have port wr_key  input  KEY_WIDTH  key for write.
REQ-009 SHALL have port wr_data  input  DATA_WIDTH  data for write.
REQ-010 SHALL have port lookup_req  input  1  lookup command.
REQ-011 SHALL have port lookup_key  input  KEY_WIDTH  key for lookup.
REQ-012 SHALL have port busy  output  1  high while an operation is in progress; commands ignored.
REQ-013 SHALL have port resp_valid  output  1  one-cycle lookup-completion pulse.
REQ-014 SHALL have port resp_hit  output  1  key found; qualified by resp_valid.
REQ-015 SHALL have port resp_data  output  DATA_WIDTH  found data; 0 on miss; qualified by resp_valid.
REQ-016 SHALL have port wr_done  output  1  one-cycle write-completion pulse.
REQ-017 SHALL have port wr_overflow  output  1  one-cycle pulse with wr_done when a new key is dropped because the table is full.
REQ-018 SHALL have port count  output  DATA_NUMBER_LOG2+1  number of valid entries, 0..N.

Function
REQ-019 SHALL store up to N key/data pairs in entries 0..count-1, keys unique.
REQ-020 SHALL implement FSM states IDLE, SEARCH, RESP; busy = (state != IDLE).
REQ-021 SHALL accept a command only in IDLE; priority clr > wr_en > lookup_req when simultaneous; lower-priority commands in that cycle are discarded.
REQ-022 SHALL latch key (and data for writes) and operation type on acceptance at edge T.
REQ-023 SHALL, on accepted lookup/write with count = 0, go IDLE -> RESP directly (miss).
REQ-024 SHALL otherwise go IDLE -> SEARCH with index 0, comparing one entry per cycle.
REQ-025 SHALL go SEARCH -> RESP on key match at index i, or after comparing index count-1 without match (miss); else index+1.
REQ-026 SHALL spend exactly one cycle in RESP, then return to IDLE.
REQ-027 SHALL, for a lookup, assert resp_valid in the RESP cycle with resp_hit/resp_data; hit at index i -> resp_valid in cycle T+2+i; miss with count = n > 0 -> cycle T+1+n; count = 0 -> cycle T+1.
REQ-028 SHALL, for a write, assert wr_done in the RESP cycle (same latency as REQ-027) and at that edge: hit -> overwrite data at index i, count unchanged; miss and count < N -> append at index count, count+1; miss and count = N -> table unchanged, wr_overflow = 1.
REQ-029 SHALL keep resp_valid, resp_hit, resp_data, wr_done, wr_overflow at 0 in all cycles except the qualifying RESP cycle.
REQ-030 SHALL, on accepted clr in IDLE, set count to 0 at the next edge without response pulses; stored data need not be erased.
REQ-031 SHALL treat clr asserted while busy as abort: next edge -> IDLE, count = 0, no resp_valid/wr_done for the aborted operation; wr_en/lookup_req while busy are ignored.
REQ-032 SHALL keep count saturated at N; it never wraps.

Reset
REQ-033 SHALL, on rst high at a rising edge, enter IDLE, set count = 0, and drive busy, resp_valid, resp_hit, resp_data, wr_done, wr_overflow to 0, overriding any command or operation in progress.
REQ-034 SHALL treat rst mid-operation as abort: no completion pulse for that operation.

Verification
REQ-035 SHALL pass: after reset, lookup key 4'h5 -> resp_valid at T+1, resp_hit = 0, resp_data = 0, count = 0.
REQ-036 SHALL pass: write (3,2'b01), (7,2'b10), (9,2'b11); lookup 7 -> resp_valid at T+3, hit = 1, data = 2'b10; lookup 4 -> resp_valid at T+4, hit = 0.
REQ-037 SHALL pass: write (3,2'b01) then (3,2'b10) -> count stays 1, lookup 3 returns 2'b10.
REQ-038 SHALL pass: 8 writes of distinct keys 0..7, then write key 8 -> wr_done and wr_overflow together, count = 8, lookup 8 misses, lookup 0 hits.
REQ-039 SHALL pass: same-cycle clr+wr_en+lookup_req in IDLE -> count = 0, no response pulses; clr during a SEARCH -> IDLE next cycle, no resp_valid.
REQ-040 SHALL pass: rst asserted mid-SEARCH -> IDLE, count = 0, all outputs 0 next cycle, no completion pulse.

Source files
------------

// File: rtl/my_associative_lookup.sv
// Purpose: small associative key/data table with insert/update, lookup and clear, searched linearly.
// Latency: lookup/write completes after 1 (empty table), 2+i (hit at entry i) or 1+count (miss) cycles.
// Backpressure: busy is high while an operation runs; commands presented while busy are dropped (clr aborts).
module my_associative_lookup #(
    parameter int KEY_WIDTH        = 4,
    parameter int DATA_WIDTH       = 2,
    parameter int DATA_NUMBER_LOG2 = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        wr_en,
    input  logic [KEY_WIDTH-1:0]        wr_key,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic                        lookup_req,
    input  logic [KEY_WIDTH-1:0]        lookup_key,
    output logic                        busy,
    output logic                        resp_valid,
    output logic                        resp_hit,
    output logic [DATA_WIDTH-1:0]       resp_data,
    output logic                        wr_done,
    output logic                        wr_overflow,
    output logic [DATA_NUMBER_LOG2:0]   count
);

    localparam int N = 1 << DATA_NUMBER_LOG2;
    localparam logic [DATA_NUMBER_LOG2:0] FULL = (DATA_NUMBER_LOG2+1)'(N);
    localparam logic [DATA_NUMBER_LOG2:0] ONE  = (DATA_NUMBER_LOG2+1)'(1);

    typedef enum logic [1:0] {IDLE, SEARCH, RESP} state_t;

    state_t                      state_q, state_d;
    logic [DATA_NUMBER_LOG2-1:0] idx_q, idx_d;
    logic [KEY_WIDTH-1:0]        key_q, key_d;
    logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
    logic                        is_wr_q, is_wr_d;
    logic                        hit_q, hit_d;
    logic [DATA_WIDTH-1:0]       hit_data_q, hit_data_d;
    logic [DATA_NUMBER_LOG2:0]   count_q, count_d;

    logic [KEY_WIDTH-1:0]        keys_q [N];
    logic [DATA_WIDTH-1:0]       vals_q [N];

    logic                        mem_we;
    logic [DATA_NUMBER_LOG2-1:0] widx;

    // Next-state logic: command acceptance, one-entry-per-cycle search, completion and clear/abort.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        key_d      = key_q;
        wdata_d    = wdata_q;
        is_wr_d    = is_wr_q;
        hit_d      = hit_q;
        hit_data_d = hit_data_q;
        count_d    = count_q;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    count_d = '0;
                end else if (wr_en || lookup_req) begin
                    key_d      = wr_en ? wr_key : lookup_key;
                    wdata_d    = wr_data;
                    is_wr_d    = wr_en;
                    hit_d      = 1'b0;
                    hit_data_d = '0;
                    idx_d      = '0;
                    state_d    = (count_q == '0) ? RESP : SEARCH;
                end
            end
            SEARCH: begin
                if (clr) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (keys_q[idx_q] == key_q) begin
                    // idx_q is left pointing at the matching entry for the write-back.
                    hit_d      = 1'b1;
                    hit_data_d = vals_q[idx_q];
                    state_d    = RESP;
                end else if ({1'b0, idx_q} == count_q - ONE) begin
                    state_d = RESP;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (clr) begin
                    count_d = '0;
                end else if (is_wr_q && !hit_q && count_q != FULL) begin
                    count_d = count_q + ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            key_q      <= '0;
            wdata_q    <= '0;
            is_wr_q    <= 1'b0;
            hit_q      <= 1'b0;
            hit_data_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            key_q      <= key_d;
            wdata_q    <= wdata_d;
            is_wr_q    <= is_wr_d;
            hit_q      <= hit_d;
            hit_data_q <= hit_data_d;
            count_q    <= count_d;
        end
    end

    // Write-back happens at the end of RESP: overwrite on hit, append on miss when room remains.
    assign mem_we = (state_q == RESP) && is_wr_q && !clr && !rst && (hit_q || count_q != FULL);
    assign widx   = hit_q ? idx_q : count_q[DATA_NUMBER_LOG2-1:0];

    // Entry storage; only entries below count are ever read, so no reset is needed.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            keys_q[widx] <= key_q;
            vals_q[widx] <= wdata_q;
        end
    end

    // Completion pulses exist only in RESP and are suppressed when a clear aborts that cycle.
    assign busy        = (state_q != IDLE);
    assign resp_valid  = (state_q == RESP) && !is_wr_q && !clr;
    assign resp_hit    = resp_valid && hit_q;
    assign resp_data   = resp_valid ? hit_data_q : '0;
    assign wr_done     = (state_q == RESP) && is_wr_q && !clr;
    assign wr_overflow = wr_done && !hit_q && (count_q == FULL);
    assign count       = count_q;

endmodule

// File: tb/tb_my_associative_lookup.sv
// Purpose: scoreboard bench for my_associative_lookup against a queue-based table model.
// Latency: expected completion cycle is derived from the model's entry position and fill level.
// Backpressure: the driver waits for busy to drop before issuing the next command.
module tb_my_associative_lookup;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_key = '0;
    logic [1:0] wr_data = '0;
    logic       lookup_req = 1'b0;
    logic [3:0] lookup_key = '0;
    logic       busy, resp_valid, resp_hit, wr_done, wr_overflow;
    logic [1:0] resp_data;
    logic [3:0] count;

    my_associative_lookup #(.KEY_WIDTH(4), .DATA_WIDTH(2), .DATA_NUMBER_LOG2(3)) dut (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_key(wr_key), .wr_data(wr_data),
        .lookup_req(lookup_req), .lookup_key(lookup_key), .busy(busy), .resp_valid(resp_valid),
        .resp_hit(resp_hit), .resp_data(resp_data), .wr_done(wr_done), .wr_overflow(wr_overflow),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       is_wr;
        bit       hit;
        bit [1:0] data;
        bit       ovf;
        int       due;
    } exp_t;

    exp_t     exp_q[$];
    bit [3:0] m_keys[$];
    bit [1:0] m_vals[$];
    int       errors = 0;
    int       checks = 0;
    int       ncyc = 0;
    bit       mon_en = 1'b0;

    // Monitor: counts cycles, pops the scoreboard on every completion pulse, checks idle outputs.
    always @(negedge clk) begin
        exp_t     e;
        bit [4:0] got, want;
        ncyc++;
        if (mon_en) begin
            if (resp_valid || wr_done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: got resp_valid=%0b wr_done=%0b, required no pulse", resp_valid, wr_done);
                end else begin
                    e    = exp_q.pop_front();
                    got  = {resp_valid, wr_done, resp_hit, resp_data};
                    want = {!e.is_wr, e.is_wr, !e.is_wr && e.hit, e.is_wr ? 2'b00 : e.data};
                    if (got != want || wr_overflow != (e.is_wr && e.ovf)) begin
                        errors++;
                        $display("FAIL resp_fields: got v/d/h/data=%b ovf=%0b, required %b ovf=%0b",
                                 got, wr_overflow, want, e.is_wr && e.ovf);
                    end
                    checks++;
                    if (ncyc != e.due) begin
                        errors++;
                        $display("FAIL resp_latency: got cycle %0d, required %0d", ncyc, e.due);
                    end
                end
            end else begin
                checks++;
                if (resp_hit || resp_data != 2'b00 || wr_overflow) begin
                    errors++;
                    $display("FAIL idle_outputs: got hit=%0b data=%0d ovf=%0b, required all 0",
                             resp_hit, resp_data, wr_overflow);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: got busy=%0b after 40 cycles, required 0", name, busy);
        end
    endtask

    // Drive a single command for exactly one rising edge.
    task automatic drive_cmd(input bit c, input bit w, input bit l, input bit [3:0] k, input bit [1:0] d);
        clr = c; wr_en = w; lookup_req = l;
        wr_key = k; lookup_key = k; wr_data = d;
        @(posedge clk);
        #1;
        clr = 1'b0; wr_en = 1'b0; lookup_req = 1'b0;
    endtask

    // Issue a write or lookup, predict its result from the model, and verify the resulting count.
    task automatic do_op(input bit is_wr, input bit [3:0] k, input bit [1:0] d);
        exp_t e;
        int   idx = -1;
        int   n;
        wait_idle("pre_op");
        #1;
        n = m_keys.size();
        foreach (m_keys[j]) if (m_keys[j] == k && idx < 0) idx = j;
        e.is_wr = is_wr;
        e.hit   = (idx >= 0);
        e.data  = e.hit ? m_vals[idx] : 2'b00;
        e.ovf   = !e.hit && n == 8;
        e.due   = ncyc + ((n == 0) ? 1 : (e.hit ? 2 + idx : 1 + n));
        if (is_wr) begin
            if (e.hit) m_vals[idx] = d;
            else if (n < 8) begin
                m_keys.push_back(k);
                m_vals.push_back(d);
            end
        end
        exp_q.push_back(e);
        drive_cmd(1'b0, is_wr, !is_wr, k, d);
        wait_idle("op");
        #1;
        chk("count_after_op", int'(count), m_keys.size());
    endtask

    task automatic clear_model();
        m_keys.delete();
        m_vals.delete();
    endtask

    initial begin
        // Reset and check the quiescent state.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_count", int'(count), 0);
        chk("reset_pulses", int'({resp_valid, resp_hit, resp_data, wr_done, wr_overflow}), 0);
        mon_en = 1'b1;

        // Lookup on an empty table misses after one cycle.
        do_op(1'b0, 4'h5, 2'b00);

        // Three inserts, a hit deep in the table and a full-length miss.
        do_op(1'b1, 4'd3, 2'b01);
        do_op(1'b1, 4'd7, 2'b10);
        do_op(1'b1, 4'd9, 2'b11);
        do_op(1'b0, 4'd7, 2'b00);
        do_op(1'b0, 4'd4, 2'b00);

        // Overwrite keeps the count and replaces the data.
        @(negedge clk); #1;
        drive_cmd(1'b1, 1'b0, 1'b0, 4'd0, 2'b00);
        clear_model();
        do_op(1'b1, 4'd3, 2'b01);
        do_op(1'b1, 4'd3, 2'b10);
        do_op(1'b0, 4'd3, 2'b00);

        // Fill to capacity, then overflow with a ninth key.
        @(negedge clk); #1;
        drive_cmd(1'b1, 1'b0, 1'b0, 4'd0, 2'b00);
        clear_model();
        for (int i = 0; i < 8; i++) do_op(1'b1, 4'(i), 2'(i));
        do_op(1'b1, 4'd8, 2'b01);
        chk("full_count", int'(count), 8);
        do_op(1'b0, 4'd8, 2'b00);
        do_op(1'b0, 4'd0, 2'b00);

        // Simultaneous clr+wr_en+lookup_req: clear wins, no pulses.
        @(negedge clk); #1;
        drive_cmd(1'b1, 1'b1, 1'b1, 4'd2, 2'b11);
        clear_model();
        @(negedge clk);
        chk("clr_priority_count", int'(count), 0);
        chk("clr_priority_busy", int'(busy), 0);

        // Clear during SEARCH aborts without a response.
        do_op(1'b1, 4'd1, 2'b01);
        do_op(1'b1, 4'd2, 2'b10);
        do_op(1'b1, 4'd4, 2'b11);
        @(negedge clk); #1;
        drive_cmd(1'b0, 1'b0, 1'b1, 4'd15, 2'b00);
        @(negedge clk); #1;
        chk("abort_clr_in_search", int'(busy), 1);
        drive_cmd(1'b1, 1'b0, 1'b0, 4'd0, 2'b00);
        clear_model();
        @(negedge clk);
        chk("abort_clr_busy", int'(busy), 0);
        chk("abort_clr_count", int'(count), 0);
        repeat (5) @(negedge clk);

        // Reset during SEARCH aborts without a completion pulse.
        do_op(1'b1, 4'd6, 2'b01);
        do_op(1'b1, 4'd5, 2'b10);
        @(negedge clk); #1;
        drive_cmd(1'b0, 1'b1, 1'b0, 4'd12, 2'b11);
        @(negedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        clear_model();
        @(negedge clk);
        chk("abort_rst_outputs", int'({busy, resp_valid, resp_hit, resp_data, wr_done, wr_overflow}), 0);
        chk("abort_rst_count", int'(count), 0);
        repeat (5) @(negedge clk);

        // Randomized mix of writes, lookups and occasional clears over a 16-key space.
        for (int i = 0; i < 80; i++) begin
            int r = $urandom_range(0, 99);
            if (r < 5) begin
                wait_idle("pre_clr");
                #1;
                drive_cmd(1'b1, 1'b0, 1'b0, 4'd0, 2'b00);
                clear_model();
                @(negedge clk);
                chk("rand_clr_count", int'(count), 0);
            end else begin
                do_op(r < 55, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
            end
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
